smc_choose_seq: RTL

Sequential, parametrised successor to the SMC output selector. It takes one sorted vector of N values and selects the high group (top K elements) or the low group (bottom K elements). It produces either the plain sum or the weighted sum of that group, using one multiply-accumulate per cycle. It sits after the SMC sort stage, with valid/ready handshakes on both sides, and adds overflow detection and an optional saturation mode.

---
 rtl/smc_choose_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/smc_choose_seq.sv
// smc_choose_seq
//   Sequential group selector/accumulator that sits after the SMC sort stage.
//   It accepts one sorted vector of N unsigned elements and picks either the
//   high group (elements N-K..N-1) or the low group (elements 0..K-1). It then
//   produces the plain sum or the weighted sum (weight W_BASE+j for group
//   element j) using one multiply-accumulate per clock.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_data/in_mode are valid
//   in_ready  : block can accept an input (IDLE and not in reset)
//   in_data   : N*DATA_W packed elements, element 0 (smallest) in the LSBs
//   in_mode   : bit1 0=high group / 1=low group, bit0 0=plain / 1=weighted
//   out_valid : result available, held until out_ready
//   out_ready : downstream accepts the result
//   out_data  : result, wrapped (SAT=0) or clamped (SAT=1) to OUT_W bits
//   out_ovf   : full-precision result exceeded 2^OUT_W-1
module smc_choose_seq #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned N      = 6,
  parameter int unsigned K      = 3,
  parameter int unsigned W_BASE = 3,
  parameter int unsigned OUT_W  = 10,
  parameter int unsigned SAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_ovf
);

  // Accumulator is sized so the largest weighted group sum cannot overflow.
  localparam int unsigned AW   = DATA_W + $clog2(K * (W_BASE + K - 1) + 1);
  // Common width for the overflow comparison, whichever of AW/OUT_W is wider.
  localparam int unsigned CW   = (AW > OUT_W) ? AW : OUT_W;
  localparam int unsigned IW   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned LAST = K - 1;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [N*DATA_W-1:0] data_q;
  logic [1:0]          mode_q;
  logic [AW-1:0]       acc;
  logic [IW-1:0]       idx;

  logic [DATA_W-1:0]   elem;
  logic [AW-1:0]       term;
  logic [AW-1:0]       acc_sum;
  logic [CW-1:0]       sum_ext;
  logic                ovf;
  logic [OUT_W-1:0]    res;

  // Group element selection is a small mux over the K candidates rather than
  // a variable part-select, so the base offset folds into constants.
  always_comb begin
    elem = '0;
    for (int unsigned j = 0; j < K; j++) begin
      if (idx == IW'(j)) begin
        elem = mode_q[1] ? data_q[j*DATA_W +: DATA_W]
                         : data_q[(N-K+j)*DATA_W +: DATA_W];
      end
    end
    term    = mode_q[0] ? AW'(elem) * AW'(W_BASE + 32'(idx)) : AW'(elem);
    acc_sum = acc + term;
    sum_ext = CW'(acc_sum);
    ovf     = sum_ext > CW'({OUT_W{1'b1}});
    res     = (ovf && (SAT != 0)) ? '1 : OUT_W'(sum_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ACC;
      end
      ACC: begin
        if (idx == IW'(LAST)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset wins over the handshake, so nothing may be offered as accepted.
    if (rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      mode_q    <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            mode_q <= in_mode;
            acc    <= '0;
            idx    <= '0;
          end
        end
        ACC: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          if (idx == IW'(LAST)) begin
            out_data  <= res;
            out_ovf   <= ovf;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
